// File: rtl/step_pulse_gen_if.sv
// Button/step bundle between the push-button front end and the counter.
// master: drives the raw button and consumes the pulse and level.
// slave: the pulse generator itself.
interface step_pulse_gen_if;
  logic btn_in;     // raw, asynchronous, active-high, may bounce
  logic step;       // one-cycle enable pulse per accepted press
  logic btn_level;  // debounced button level

  modport master (
    output btn_in,
    input  step,
    input  btn_level
  );

  modport slave (
    input  btn_in,
    output step,
    output btn_level
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Push-button front end: 2-flop synchronizer, debounce FSM, registered step
// pulse and debounced level. Define AUTO_REPEAT_EN to add an auto-repeat
// timer that keeps issuing steps while the button stays held.
module step_pulse_gen #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic           clk,
  input  logic           reset,  // asynchronous, active-low
  step_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StDbPress,
    StHeld,
    StDbRelease
  } state_e;

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             level_q, level_d;

  assign btn_s = s2_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;  // still waiting for the first repeat
  logic             repeat_fire;

  // Repeat timer: counts held cycles, fires after the delay, then per period.
  always_comb begin
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    repeat_fire = 1'b0;
    if (state_q == StIdle) begin
      rep_d       = '0;
      rep_first_d = 1'b1;
    end else if (state_q == StDbPress) begin
      // Cleared on entry to HELD; value is irrelevant before that.
      rep_d       = '0;
      rep_first_d = 1'b1;
    end else if (state_q == StHeld && btn_s) begin
      if (rep_q == (rep_first_q ? DelayLast : PeriodLast)) begin
        repeat_fire = 1'b1;
        rep_d       = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
    // DB_RELEASE (and the HELD exit cycle) hold the count so cadence resumes.
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic repeat_fire;
  logic unused_repeat_cfg;
  assign repeat_fire       = 1'b0;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Debounce FSM next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    level_d = level_q;
    case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StDbPress;
          cnt_d   = '0;
        end
      end
      StDbPress: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d = StHeld;
          step_d  = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StDbRelease;
          cnt_d   = '0;
        end else begin
          step_d = repeat_fire;
        end
      end
      StDbRelease: begin
        if (btn_s) begin
          state_d = StHeld;
        end else if (cnt_q == DbLast) begin
          state_d = StIdle;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      level_q <= level_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.btn_level = level_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus random button activity,
// all checked cycle by cycle against a behavioural run-length model.
module tb_step_pulse_gen;

  localparam int unsigned DbCycles     = 4;
  localparam int unsigned CntW         = 8;
  localparam int unsigned RepeatDelay  = 16;
  localparam int unsigned RepeatPeriod = 8;
  localparam int          Latency      = 2 + DbCycles;
`ifdef AUTO_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   steps_seen;
  int   ticks;

  step_pulse_gen_if bus ();

  step_pulse_gen #(
    .DB_CYCLES    (DbCycles),
    .CNT_W        (CntW),
    .REPEAT_DELAY (RepeatDelay),
    .REPEAT_PERIOD(RepeatPeriod)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: level flips once the synchronized button has disagreed with it
  // for DbCycles+1 consecutive samples; a press that flips it emits a step.
  bit m_s1, m_s2, m_level, m_step, m_first;
  int m_run, m_hold;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_step = 0;
    m_run = 0; m_hold = 0; m_first = 1;
  endtask

  task automatic model_edge(input bit btn);
    bit bs;
    bs     = m_s2;
    m_step = 0;
    if (bs != m_level) begin
      m_run++;
      if (m_run == DbCycles + 1) begin
        m_level = bs;
        m_run   = 0;
        if (bs) begin
          m_step  = 1;
          m_hold  = 0;
          m_first = 1;
        end
      end
    end else begin
      // Stable held cycle (not a rejected glitch): advance the repeat timer.
      if (RepeatEn && m_level && m_run == 0) begin
        m_hold++;
        if (m_hold == (m_first ? RepeatDelay : RepeatPeriod)) begin
          m_step  = 1;
          m_hold  = 0;
          m_first = 0;
        end
      end
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model sees the same input the DUT sampled, outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) model_edge(bus.btn_in);
    #1;
    ticks++;
    check_eq("step", 32'(bus.step), 32'(m_step));
    check_eq("level", 32'(bus.btn_level), 32'(m_level));
    if (bus.step === 1'b1) steps_seen++;
  endtask

  task automatic run(input bit v, input int n);
    bus.btn_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until a step appears; returns edges after the first sampling edge.
  task automatic wait_step(input int budget, output int lat);
    int start;
    start = ticks;
    lat   = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.step === 1'b1) begin
        lat = ticks - start - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt6;
    bus.btn_in = 1'b0;
    reset      = 1'b0;
    steps_seen = 0;
    ticks      = 0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check_eq("rst_step", 32'(bus.step), 0);
    check_eq("rst_level", 32'(bus.btn_level), 0);
    reset = 1'b1;
    run(0, 3);

    // Clean press: single step at the fixed latency, level rises with it
    bus.btn_in = 1'b1;
    steps_seen = 0;
    wait_step(30, lat);
    check_eq("press_latency", 32'(lat), 32'(Latency));
    check_eq("press_level", 32'(bus.btn_level), 1);
    run(1, 20 - Latency - 1);
    check_eq("press_steps", 32'(steps_seen), 1);
    run(0, 12);
    check_eq("release_level", 32'(bus.btn_level), 0);

    // Bounce reject
    steps_seen = 0;
    for (int i = 0; i < 8; i++) run(~i[0], 1);
    run(0, 12);
    check_eq("bounce_steps", 32'(steps_seen), 0);
    check_eq("bounce_level", 32'(bus.btn_level), 0);

    // Release glitch: level holds, no extra step; full release drops level
    steps_seen = 0;
    run(1, 20);
    run(0, 2);
    run(1, 10);
    check_eq("glitch_level", 32'(bus.btn_level), 1);
    check_eq("glitch_steps", 32'(steps_seen), RepeatEn ? steps_seen : 1);
    bus.btn_in = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.btn_level === 1'b0) begin
        lat = i;
        break;
      end
    end
    check_eq("release_latency", 32'(lat), 32'(Latency));
    run(0, 5);

    // Async reset while step is high; held button re-accepted after release
    bus.btn_in = 1'b1;
    wait_step(30, lat);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_step", 32'(bus.step), 0);
    check_eq("async_level", 32'(bus.btn_level), 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    wait_step(30, lat);
    check_eq("rst_hold_latency", 32'(lat), 32'(Latency));
    run(1, 5);
    run(0, 12);

    // Steps driving a mod-6 counter
    cnt6 = 0;
    for (int p = 0; p < 7; p++) begin
      steps_seen = 0;
      run(1, 12);
      run(0, 12);
      cnt6 = (cnt6 + steps_seen) % 6;
      check_eq("mod6", 32'(cnt6), 32'((p + 1) % 6));
    end

    // Long hold: one step without auto-repeat
    if (!RepeatEn) begin
      steps_seen = 0;
      run(1, 60);
      check_eq("hold_steps", 32'(steps_seen), 1);
      run(0, 12);
    end

    // Random segments, including mid-run async resets
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rnd_rst_step", 32'(bus.step), 0);
        check_eq("rnd_rst_level", 32'(bus.btn_level), 0);
        tick();
        #2;
        reset = 1'b1;
      end
      run(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something ever hangs.
  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
